// File: rtl/sigs_code_gen_if.sv
// rtl/sigs_code_gen_if.sv - control and chip-output bundle of the spreading-code generator
//
// Signals (master drives controls, slave drives chip outputs):
//   en            chip strobe, phase steps once per en cycle
//   advance       slip request, move forward by step extra chips
//   retard        slip request, move backward by step chips
//   step          slip magnitude in chips
//   load          load pattern and length
//   load_len      new code length (clamped to 2..CODE_LEN)
//   load_pattern  new pattern, bit i = chip i
//   code          prompt chip
//   code_e        early chip (phase+1 mod len)
//   code_l        late chip (phase-1 mod len)
//   epoch         one-cycle pulse aligned with the first chip after a wrap
//   phase         current phase index
interface sigs_code_gen_if #(
    parameter int CODE_LEN = 16,
    parameter int STEP_W   = 4,
    parameter int PH_W     = $clog2(CODE_LEN)
);
    logic                en;
    logic                advance;
    logic                retard;
    logic [STEP_W-1:0]   step;
    logic                load;
    logic [PH_W:0]       load_len;
    logic [CODE_LEN-1:0] load_pattern;
    logic                code;
    logic                code_e;
    logic                code_l;
    logic                epoch;
    logic [PH_W-1:0]     phase;

    modport master (
        output en, advance, retard, step, load, load_len, load_pattern,
        input  code, code_e, code_l, epoch, phase
    );

    modport slave (
        input  en, advance, retard, step, load, load_len, load_pattern,
        output code, code_e, code_l, epoch, phase
    );
endinterface

// File: rtl/sigs_code_gen.sv
// rtl/sigs_code_gen.sv - runtime-loadable spreading-code generator with slip control
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   sigs_code_gen_if.slave: controls in, early/prompt/late chips,
//         epoch and phase out
module sigs_code_gen #(
    parameter int                CODE_LEN = 16,
    parameter logic [CODE_LEN-1:0] SEED   = 16'hff00,
    parameter int                STEP_W   = 4,
    parameter int                PH_W     = $clog2(CODE_LEN)
) (
    input  logic           clk,
    input  logic           rst,
    sigs_code_gen_if.slave bus
);
    // Phase arithmetic is done on a biased sum P + 1 + len +/- s, which lies in
    // [2, 3*len-1]; XW bits hold it with no overflow or underflow.
    localparam int XW = PH_W + 2;
    localparam int SW = (STEP_W > PH_W + 1) ? STEP_W : PH_W + 1;
    localparam logic [PH_W:0] LEN_MAX = (PH_W + 1)'(CODE_LEN);
    localparam logic [PH_W:0] LEN_MIN = (PH_W + 1)'(2);

    logic [CODE_LEN-1:0] pattern_q;
    logic [PH_W:0]       len_q;
    logic [PH_W-1:0]     p_q;
    logic                pend_adv_q;
    logic                pend_ret_q;
    logic [PH_W-1:0]     pend_s_q;
    logic                wrap_q;

    logic [SW-1:0]   step_x;
    logic [SW-1:0]   lenm1_x;
    logic [PH_W-1:0] s_cur;
    logic            pin_req;
    logic            req_adv;
    logic            req_ret;
    logic [PH_W-1:0] s_req;
    logic            cancel;
    logic [XW-1:0]   x_sum;
    logic [XW-1:0]   len_x;
    logic [XW-1:0]   len2_x;
    logic [PH_W-1:0] p_nxt;
    logic            wrap_nxt;
    logic [PH_W-1:0] idx_e;
    logic [PH_W-1:0] idx_l;
    logic [PH_W:0]   len_clamped;

    always_comb begin
        step_x   = SW'(bus.step);
        lenm1_x  = SW'(len_q - 1'b1);
        s_cur    = (step_x > lenm1_x) ? PH_W'(lenm1_x) : PH_W'(step_x);

        // Live pins take precedence over a request parked between strobes.
        pin_req  = bus.advance | bus.retard;
        req_adv  = pin_req ? bus.advance : pend_adv_q;
        req_ret  = pin_req ? bus.retard  : pend_ret_q;
        s_req    = pin_req ? s_cur       : pend_s_q;
        cancel   = req_adv & req_ret;

        len_x    = XW'(len_q);
        len2_x   = len_x << 1;
        x_sum    = XW'(p_q) + XW'(1'b1) + len_x;
        if (req_adv && !cancel) begin
            x_sum = x_sum + XW'(s_req);
        end
        if (req_ret && !cancel) begin
            x_sum = x_sum - XW'(s_req);
        end

        // x_sum >= 2*len means P+delta >= len; a retard below zero lands in
        // [0, len) of the biased sum and never flags a wrap.
        wrap_nxt = 1'b0;
        if (x_sum >= len2_x) begin
            p_nxt    = PH_W'(x_sum - len2_x);
            wrap_nxt = 1'b1;
        end else if (x_sum >= len_x) begin
            p_nxt    = PH_W'(x_sum - len_x);
        end else begin
            p_nxt    = PH_W'(x_sum);
        end

        idx_e = ({1'b0, p_q} + 1'b1 == len_q) ? '0 : p_q + 1'b1;
        idx_l = (p_q == '0) ? PH_W'(len_q - 1'b1) : p_q - 1'b1;

        if (bus.load_len < LEN_MIN) begin
            len_clamped = LEN_MIN;
        end else if (bus.load_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end else begin
            len_clamped = bus.load_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q  <= SEED;
            len_q      <= LEN_MAX;
            p_q        <= '0;
            pend_adv_q <= 1'b0;
            pend_ret_q <= 1'b0;
            pend_s_q   <= '0;
            wrap_q     <= 1'b0;
            bus.code   <= 1'b0;
            bus.code_e <= 1'b0;
            bus.code_l <= 1'b0;
            bus.epoch  <= 1'b0;
        end else begin
            // Chip outputs sample the phase before this edge's update.
            bus.code   <= pattern_q[p_q];
            bus.code_e <= pattern_q[idx_e];
            bus.code_l <= pattern_q[idx_l];
            // wrap_q lands with the phase update, so epoch one edge later lines
            // up with the first chip presented after the wrap.
            bus.epoch  <= bus.load ? 1'b0 : wrap_q;
            wrap_q     <= 1'b0;

            if (bus.load) begin
                pattern_q  <= bus.load_pattern;
                len_q      <= len_clamped;
                p_q        <= '0;
                pend_adv_q <= 1'b0;
                pend_ret_q <= 1'b0;
                pend_s_q   <= '0;
            end else if (bus.en) begin
                p_q        <= p_nxt;
                wrap_q     <= wrap_nxt;
                pend_adv_q <= 1'b0;
                pend_ret_q <= 1'b0;
                pend_s_q   <= '0;
            end else if (bus.advance && bus.retard) begin
                pend_adv_q <= 1'b0;
                pend_ret_q <= 1'b0;
                pend_s_q   <= '0;
            end else if (pin_req) begin
                pend_adv_q <= bus.advance;
                pend_ret_q <= bus.retard;
                pend_s_q   <= s_cur;
            end
        end
    end

    assign bus.phase = p_q;
endmodule

// File: tb/tb_sigs_code_gen.sv
// tb/tb_sigs_code_gen.sv - directed self-checking bench for sigs_code_gen
module tb_sigs_code_gen;
    localparam int CODE_LEN = 16;
    localparam int STEP_W   = 4;
    localparam int PH_W     = 4;

    logic clk;
    logic rst_n;
    logic clk_run;
    int   checks;
    int   errors;

    sigs_code_gen_if #(.CODE_LEN(CODE_LEN), .STEP_W(STEP_W), .PH_W(PH_W)) bus ();

    sigs_code_gen #(
        .CODE_LEN (CODE_LEN),
        .SEED     (16'hff00),
        .STEP_W   (STEP_W),
        .PH_W     (PH_W)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic a, input logic r, input logic [3:0] st);
        bus.en      = e;
        bus.advance = a;
        bus.retard  = r;
        bus.step    = st;
        tick();
        bus.en      = 1'b0;
        bus.advance = 1'b0;
        bus.retard  = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] ln, input logic [15:0] pat);
        bus.load         = 1'b1;
        bus.load_len     = ln;
        bus.load_pattern = pat;
        tick();
        bus.load         = 1'b0;
    endtask

    // Strobe en every cycle from P=0 and compare against the pattern model.
    task automatic run_check(input int ncyc, input logic [15:0] pat, input int len);
        logic [15:0] p;
        p = pat;
        for (int n = 1; n <= ncyc; n++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0);
            chk($sformatf("code n=%0d", n),   bus.code,   p[(n - 1) % len]);
            chk($sformatf("code_e n=%0d", n), bus.code_e, p[n % len]);
            chk($sformatf("code_l n=%0d", n), bus.code_l, p[(n + len - 2) % len]);
            chk($sformatf("phase n=%0d", n),  bus.phase,  n % len);
            chk($sformatf("epoch n=%0d", n),  bus.epoch,  (n > len) && ((n - 1) % len == 0));
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        clk_run          = 1'b1;
        rst_n            = 1'b0;
        bus.en           = 1'b0;
        bus.advance      = 1'b0;
        bus.retard       = 1'b0;
        bus.step         = '0;
        bus.load         = 1'b0;
        bus.load_len     = '0;
        bus.load_pattern = '0;

        // Reset state
        #2;
        chk("rst_code",   bus.code,   1'b0);
        chk("rst_code_e", bus.code_e, 1'b0);
        chk("rst_code_l", bus.code_l, 1'b0);
        chk("rst_epoch",  bus.epoch,  1'b0);
        chk("rst_phase",  bus.phase,  4'd0);
        tick();
        tick();
        chk("rst_hold_phase", bus.phase, 4'd0);
        rst_n = 1'b1;

        // Free-running SEED sequence: 8 zeros, 8 ones, epoch every 16
        run_check(40, 16'hff00, 16);

        // Slips at P=3
        do_load(5'd16, 16'hff00);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("p3_setup", bus.phase, 4'd3);
        drive(1'b1, 1'b1, 1'b0, 4'd1);
        chk("adv1_p5", bus.phase, 4'd5);
        do_load(5'd16, 16'hff00);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 1'b1, 4'd1);
        chk("ret1_hold", bus.phase, 4'd3);
        drive(1'b1, 1'b0, 1'b1, 4'd2);
        chk("ret2_p2", bus.phase, 4'd2);

        // Pending slip captured between strobes
        do_load(5'd16, 16'hff00);
        drive(1'b0, 1'b1, 1'b0, 4'd3);
        chk("pend_cap_p", bus.phase, 4'd0);
        repeat (4) tick();
        chk("pend_idle_p", bus.phase, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("pend_use_p4", bus.phase, 4'd4);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("pend_consumed_p5", bus.phase, 4'd5);
        drive(1'b1, 1'b1, 1'b1, 4'd3);
        chk("both_cancel_p6", bus.phase, 4'd6);
        drive(1'b0, 1'b1, 1'b0, 4'd2);
        drive(1'b0, 1'b1, 1'b1, 4'd2);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("both_clear_pend_p7", bus.phase, 4'd7);

        // Length 7 pattern 0001101 -> 1,0,1,1,0,0,0
        do_load(5'd7, 16'h000d);
        chk("load_epoch", bus.epoch, 1'b0);
        chk("load_phase", bus.phase, 4'd0);
        run_check(22, 16'h000d, 7);

        // Length clamps
        do_load(5'd1, 16'h0001);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("len_min_p1", bus.phase, 4'd1);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("len_min_p0", bus.phase, 4'd0);
        do_load(5'd20, 16'hff00);
        drive(1'b1, 1'b0, 1'b1, 4'd3);
        chk("len_max_ret_p14", bus.phase, 4'd14);

        // Retard below zero: no epoch; advance past the end: epoch
        do_load(5'd16, 16'hff00);
        drive(1'b1, 1'b0, 1'b1, 4'd3);
        chk("ret_wrap_p14", bus.phase, 4'd14);
        tick();
        chk("ret_wrap_no_epoch", bus.epoch, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("p15", bus.phase, 4'd15);
        drive(1'b1, 1'b1, 1'b0, 4'd2);
        chk("adv_wrap_p2", bus.phase, 4'd2);
        chk("adv_wrap_epoch_early", bus.epoch, 1'b0);
        tick();
        chk("adv_wrap_epoch", bus.epoch, 1'b1);
        chk("adv_wrap_code", bus.code, 1'b0);
        tick();
        chk("adv_wrap_epoch_off", bus.epoch, 1'b0);

        // Step clamp with len=7
        do_load(5'd7, 16'h000d);
        drive(1'b1, 1'b1, 1'b0, 4'd15);
        chk("adv_clamp_p0", bus.phase, 4'd0);
        drive(1'b1, 1'b0, 1'b1, 4'd15);
        chk("ret_clamp_p2", bus.phase, 4'd2);

        // en held low: static outputs
        do_load(5'd16, 16'hff00);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 4'd0);
        chk("hold_code_pre", bus.code, 1'b1);
        tick();
        chk("hold_code", bus.code, 1'b1);
        chk("hold_phase", bus.phase, 4'd10);
        tick();
        chk("hold_phase2", bus.phase, 4'd10);

        // Asynchronous reset with the clock stopped
        @(negedge clk);
        clk_run = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_code",   bus.code,   1'b0);
        chk("arst_code_e", bus.code_e, 1'b0);
        chk("arst_code_l", bus.code_l, 1'b0);
        chk("arst_epoch",  bus.epoch,  1'b0);
        chk("arst_phase",  bus.phase,  4'd0);
        #10;
        rst_n   = 1'b1;
        clk_run = 1'b1;
        run_check(20, 16'hff00, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sigs_code_gen.md
Name: sigs_code_gen

Overview:
- Parametrised spreading-code generator for the PSK correlator. It is the successor to the fixed 16-chip rotating code source.
- Holds a runtime-loadable chip pattern of programmable length and steps a phase index on a chip strobe.
- Supports multi-chip advance/retard slips for code-phase search, with pending-slip capture between strobes.
- Emits early/prompt/late chips, an epoch pulse and the current phase to the correlator and tracking loop.

Parameters:
- CODE_LEN, 16, maximum and reset code length in chips (>=2).
- SEED, 16'hff00, reset pattern, CODE_LEN bits; bit i = chip i.
- STEP_W, 4, width of slip-step input.
- PH_W, $clog2(CODE_LEN), width of phase index.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  chip strobe; phase steps once per en cycle.
- advance  input  1  slip request: move forward by step extra chips.
- retard  input  1  slip request: move backward by step chips relative to normal step.
- step  input  STEP_W  slip magnitude in chips.
- load  input  1  load pattern and length.
- load_len  input  PH_W+1  new code length.
- load_pattern  input  CODE_LEN  new pattern, bit i = chip i.
- code  output  1  prompt chip.
- code_e  output  1  early chip (index phase+1 mod len).
- code_l  output  1  late chip (index phase-1 mod len).
- epoch  output  1  one-cycle pulse at code start.
- phase  output  PH_W  current phase index P.

Behaviour:
- Reset (rst low, immediate):
  - pattern=SEED, len=CODE_LEN, P=0, pending slip cleared.
  - code=code_e=code_l=epoch=0, phase=0.
- Outputs registered. Each clock: code<=pattern[P], code_e<=pattern[(P+1)%len], code_l<=pattern[(P+len-1)%len], using P before that edge's update. Latency is one cycle from P to chip outputs.
- Priority per cycle: load > en step > slip capture.
- Load:
  - pattern<=load_pattern; len<=clamp(load_len, 2, CODE_LEN); P<=0; pending cleared; en and slips that cycle ignored.
  - Chips beyond len are ignored.
- Effective step: s = min(step, len-1).
  - A request is the current advance/retard pins if either is high, otherwise the pending request.
  - advance and retard together cancel: delta=1, pending cleared.
- en=1:
  - delta = 1, or 1+s on advance, or 1-s on retard.
  - P <= (P+delta) mod len, computed without overflow for every delta in [2-len, len].
  - Pending request is consumed (cleared).
  - retard with s=1 holds P.
- en=0 with advance or retard high: latch request and s into pending; a newer request overwrites the older one. P unchanged.
- Epoch:
  - Wrap event: on an en update where P+delta >= len, or the new P == 0 with delta>0.
  - Retard wrapping below 0 never flags.
  - epoch is delayed to align with code, i.e. high in the cycle code first presents chip 0 after the wrap.
  - Load does not pulse epoch.
- en held low: P and outputs static; code repeats pattern[P].
- Reset asserted mid-operation overrides everything asynchronously. On release, the sequence restarts from chip 0 of SEED.

Test Plan:
- Reset, then en=1 every cycle, default SEED -> code shows 8 zeros then 8 ones, period 16; epoch high every 16th cycle aligned with first 0; phase counts 0..15.
- At P=3: advance with step=1, en=1 -> P=5. At P=3: retard with step=1 -> P=3; retard with step=2 -> P=2.
- advance with step=3 while en=0, en asserted 5 cycles later -> P jumps +4 on that en; advance+retard in one cycle -> P +1 only, pending cleared.
- load with load_len=7, load_pattern=7'b0001101 -> code sequence 1,0,1,1,0,0,0 repeating, epoch every 7 en. load_len=1 gives len 2; load_len=20 gives len 16.
- P=0, len=16, retard with step=3 -> P=14, no epoch. P=15, advance with step=2 -> P=2, epoch pulses. step=15 with len=7 -> s clamped to 6.
- Pull rst low mid-run with clk stopped -> all outputs 0 immediately; release -> code restarts at SEED chip 0; verify code_e/code_l equal prompt shifted by -1/+1 cycle.
